// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder: two-stage pipelined carry-select adder with valid/ready
// handshakes on both sides.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout, ovf)
//   sum                  a+b+cin modulo 2^WIDTH
//   cout                 carry out of bit WIDTH-1
//   ovf                  signed overflow, only when CSEL_OVF_EN is defined
//
// Stage 1 registers the lower-half sum/carry and both upper-half candidates
// (carry-in 0 and 1). Stage 2 picks a candidate with the registered lower
// carry and registers the final result.
//
// Parameters: WIDTH (even, >= 4), SPLIT (lower-half width, 1..WIDTH-1).
// Optional feature macro: CSEL_OVF_EN (adds the ovf port and MSB regs).
module csel_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HW = WIDTH - SPLIT;

  // ---------------------------------------------------------------
  // Handshake / stall control
  // ---------------------------------------------------------------
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_in_xfer;

  logic r_s1_valid;
  logic r_out_valid;

  // Stage 2 may load when it is empty or its result leaves this cycle.
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_in_xfer = in_valid && w_s1_adv;

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;

  // ---------------------------------------------------------------
  // Stage 1 combinational: lower half and both upper candidates
  // ---------------------------------------------------------------
  logic [SPLIT-1:0] w_a_lo;
  logic [SPLIT-1:0] w_b_lo;
  logic [HW-1:0]    w_a_hi;
  logic [HW-1:0]    w_b_hi;
  logic [SPLIT:0]   w_lo;
  logic [HW:0]      w_hi0;
  logic [HW:0]      w_hi1;

  assign w_a_lo = a[SPLIT-1:0];
  assign w_b_lo = b[SPLIT-1:0];
  assign w_a_hi = a[WIDTH-1:SPLIT];
  assign w_b_hi = b[WIDTH-1:SPLIT];

  assign w_lo  = {1'b0, w_a_lo}
               + {1'b0, w_b_lo}
               + {{SPLIT{1'b0}}, cin};

  // Both upper sums are built independently so neither waits on the
  // lower-half carry chain.
  assign w_hi0 = {1'b0, w_a_hi}
               + {1'b0, w_b_hi};
  assign w_hi1 = {1'b0, w_a_hi}
               + {1'b0, w_b_hi}
               + {{HW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------
  logic [SPLIT-1:0] r_lo_sum;
  logic             r_lo_c;
  logic [HW:0]      r_hi0;
  logic [HW:0]      r_hi1;
`ifdef CSEL_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_lo_sum   <= '0;
      r_lo_c     <= 1'b0;
      r_hi0      <= '0;
      r_hi1      <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_lo_sum <= w_lo[SPLIT-1:0];
        r_lo_c   <= w_lo[SPLIT];
        r_hi0    <= w_hi0;
        r_hi1    <= w_hi1;
      end
    end
  end

`ifdef CSEL_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (w_in_xfer) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end
  end
`endif

  // ---------------------------------------------------------------
  // Stage 2 combinational: carry-select mux
  // ---------------------------------------------------------------
  logic [HW:0]      w_hi_sel;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_cout_nxt;

  assign w_hi_sel   = r_lo_c ? r_hi1 : r_hi0;
  assign w_sum_nxt  = {w_hi_sel[HW-1:0], r_lo_sum};
  assign w_cout_nxt = w_hi_sel[HW];

`ifdef CSEL_OVF_EN
  logic w_ovf_nxt;

  // Like-signed operands producing a result of the other sign.
  assign w_ovf_nxt = (r_a_msb == r_b_msb)
                  && (w_sum_nxt[WIDTH-1] != r_a_msb);
`endif

  // ---------------------------------------------------------------
  // Stage 2 registers (held while out_valid & !out_ready)
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_cout_nxt;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef CSEL_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
